// File: rtl/argmin_stream_pkg.sv
// argmin_stream shared package: sizing helpers and second-minimum merge.
// Imported by the lane tree and the streaming top.
package argmin_pkg;

  localparam int MAXW = 32;

  typedef logic [MAXW-1:0] wval_t;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

  function automatic int cwidth(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  function automatic int beats(input int nk, input int l);
    return nk / l;
  endfunction

  // Second-smallest of the union of two (min, second) pairs.
  function automatic wval_t min2_merge(
    input wval_t amin,
    input wval_t asec,
    input wval_t bmin,
    input wval_t bsec
  );
    wval_t hi;
    wval_t lo;
    hi = (amin > bmin) ? amin : bmin;
    lo = (asec < bsec) ? asec : bsec;
    return (hi < lo) ? hi : lo;
  endfunction

endpackage

// File: rtl/argmin_stream_if.sv
// argmin_stream handshake bundle: input beat stream and result stream.
// slave = the reducer, master = the producer/consumer side.
interface argmin_stream_if #(
  parameter int VALUE_WIDTH = 8,
  parameter int KEY_WIDTH   = 7,
  parameter int LANES       = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES*VALUE_WIDTH-1:0] in_vals;
  logic                         out_valid;
  logic                         out_ready;
  logic [VALUE_WIDTH-1:0]       out_min_val;
  logic [KEY_WIDTH-1:0]         out_min_key;
  logic [VALUE_WIDTH-1:0]       out_sec_val;

  modport slave (
    input  in_valid, in_vals, out_ready,
    output in_ready, out_valid,
    output out_min_val, out_min_key, out_sec_val
  );

  modport master (
    output in_valid, in_vals, out_ready,
    input  in_ready, out_valid,
    input  out_min_val, out_min_key, out_sec_val
  );
endinterface

// File: rtl/argmin_lane_tree.sv
// argmin_lane_tree: binary min tree over one beat with second-min tracking.
// vals_i: LANES costs; min_o/key_o (local lane)/sec_o: beat result.
module argmin_lane_tree
  import argmin_pkg::*;
#(
  parameter int VALUE_WIDTH = 8,
  parameter int LANES       = 4,
  parameter int LW          = cwidth(LANES)
) (
  input  logic [LANES*VALUE_WIDTH-1:0] vals_i,
  output logic [VALUE_WIDTH-1:0]       min_o,
  output logic [LW-1:0]                key_o,
  output logic [VALUE_WIDTH-1:0]       sec_o
);

  localparam int P = 1 << clog2(LANES);

  // Heap-ordered nodes: root at 1, leaves at P..2P-1.
  // Padding leaves are all ones, the identity for both min and second.
  logic [VALUE_WIDTH-1:0] nmin [2*P];
  logic [VALUE_WIDTH-1:0] nsec [2*P];
  logic [LW-1:0]          nkey [2*P];

  always_comb begin
    for (int n = 0; n < 2*P; n++) begin
      nmin[n] = '1;
      nsec[n] = '1;
      nkey[n] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      nmin[P+i] = vals_i[i*VALUE_WIDTH +: VALUE_WIDTH];
      nkey[P+i] = LW'(i);
    end
    for (int n = P - 1; n >= 1; n--) begin
      // Right child wins only when strictly smaller: lower lane keeps ties.
      if (nmin[2*n+1] < nmin[2*n]) begin
        nmin[n] = nmin[2*n+1];
        nkey[n] = nkey[2*n+1];
      end else begin
        nmin[n] = nmin[2*n];
        nkey[n] = nkey[2*n];
      end
      nsec[n] = VALUE_WIDTH'(min2_merge(
        wval_t'(nmin[2*n]), wval_t'(nsec[2*n]),
        wval_t'(nmin[2*n+1]), wval_t'(nsec[2*n+1])));
    end
  end

  assign min_o = nmin[1];
  assign key_o = nkey[1];
  assign sec_o = nsec[1];

endmodule

// File: rtl/argmin_stream.sv
// argmin_stream: per-pixel min cost, its disparity and second-min cost.
// clk/rst_n plain; bus (slave) carries input beats and the result.
module argmin_stream
  import argmin_pkg::*;
#(
  parameter int VALUE_WIDTH = 8,
  parameter int KEY_WIDTH   = 7,
  parameter int NUM_KEYS    = 64,
  parameter int LANES       = 4
) (
  input logic            clk,
  input logic            rst_n,
  argmin_stream_if.slave bus
);

  localparam int BEATS = beats(NUM_KEYS, LANES);
  localparam int CW    = cwidth(BEATS);
  localparam int LW    = cwidth(LANES);

  if (LANES < 1) begin : g_bad_lanes
    $error("LANES must be at least 1");
  end
  if (NUM_KEYS % LANES != 0) begin : g_bad_split
    $error("NUM_KEYS must be a multiple of LANES");
  end
  if ((1 << KEY_WIDTH) < NUM_KEYS) begin : g_bad_key
    $error("KEY_WIDTH too small for NUM_KEYS");
  end
  if (VALUE_WIDTH > MAXW) begin : g_bad_val
    $error("VALUE_WIDTH exceeds merge width");
  end

  logic [VALUE_WIDTH-1:0] b_min;
  logic [VALUE_WIDTH-1:0] b_sec;
  logic [LW-1:0]          b_lkey;
  logic [KEY_WIDTH-1:0]   b_key;

  logic [CW-1:0]          beat_cnt_q, beat_cnt_d;
  logic [VALUE_WIDTH-1:0] acc_min_q, acc_min_d;
  logic [VALUE_WIDTH-1:0] acc_sec_q, acc_sec_d;
  logic [KEY_WIDTH-1:0]   acc_key_q, acc_key_d;
  logic [VALUE_WIDTH-1:0] out_min_q, out_min_d;
  logic [VALUE_WIDTH-1:0] out_sec_q, out_sec_d;
  logic [KEY_WIDTH-1:0]   out_key_q, out_key_d;
  logic                   out_valid_q, out_valid_d;

  logic [VALUE_WIDTH-1:0] m_min;
  logic [VALUE_WIDTH-1:0] m_sec;
  logic [KEY_WIDTH-1:0]   m_key;

  logic in_ready;
  logic in_fire;
  logic out_fire;
  logic is_first;
  logic is_last;

  argmin_lane_tree #(
    .VALUE_WIDTH(VALUE_WIDTH),
    .LANES      (LANES),
    .LW         (LW)
  ) u_tree (
    .vals_i(bus.in_vals),
    .min_o (b_min),
    .key_o (b_lkey),
    .sec_o (b_sec)
  );

  assign in_ready = !out_valid_q || bus.out_ready;
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = out_valid_q && bus.out_ready;
  assign is_first = (beat_cnt_q == '0);
  assign is_last  = (beat_cnt_q == CW'(BEATS - 1));

  assign b_key = KEY_WIDTH'(int'(beat_cnt_q) * LANES + int'(b_lkey));

  // Beat result merged into the running accumulator.
  always_comb begin
    m_min = b_min;
    m_key = b_key;
    m_sec = b_sec;
    if (!is_first) begin
      if (b_min < acc_min_q) begin
        m_min = b_min;
        m_key = b_key;
      end else begin
        m_min = acc_min_q;
        m_key = acc_key_q;
      end
      m_sec = VALUE_WIDTH'(min2_merge(
        wval_t'(acc_min_q), wval_t'(acc_sec_q),
        wval_t'(b_min), wval_t'(b_sec)));
    end
  end

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    acc_min_d   = acc_min_q;
    acc_sec_d   = acc_sec_q;
    acc_key_d   = acc_key_q;
    out_min_d   = out_min_q;
    out_sec_d   = out_sec_q;
    out_key_d   = out_key_q;
    out_valid_d = out_valid_q;
    if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (in_fire) begin
      beat_cnt_d = is_last ? '0 : beat_cnt_q + CW'(1);
      acc_min_d  = m_min;
      acc_sec_d  = m_sec;
      acc_key_d  = m_key;
      if (is_last) begin
        out_min_d   = m_min;
        out_sec_d   = m_sec;
        out_key_d   = m_key;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      acc_min_q   <= '0;
      acc_sec_q   <= '0;
      acc_key_q   <= '0;
      out_min_q   <= '0;
      out_sec_q   <= '0;
      out_key_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      acc_min_q   <= acc_min_d;
      acc_sec_q   <= acc_sec_d;
      acc_key_q   <= acc_key_d;
      out_min_q   <= out_min_d;
      out_sec_q   <= out_sec_d;
      out_key_q   <= out_key_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_min_val = out_min_q;
  assign bus.out_min_key = out_key_q;
  assign bus.out_sec_val = out_sec_q;

endmodule
